input_module: RTL and testbench

Memory-mapped input peripheral: the read-side counterpart of the output register bank. An external producer pushes 32-bit words through a valid/ready handshake into an internal FIFO. The CPU datapath drains the FIFO and polls status through load accesses on the same 5-bit I/O address space and the same clock as the rest of the single-cycle core.

---
 rtl/io_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/input_module.sv | 85 ++++++++
 tb/tb_input_module.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared I/O address map, status bit layout and status word builder
package io_pkg;

  localparam logic [4:0] ADDR_DATA   = 5'd0;
  localparam logic [4:0] ADDR_STATUS = 5'd1;
  localparam logic [4:0] ADDR_COUNT  = 5'd2;

  localparam int ST_NEMPTY = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_UFLOW  = 2;
  localparam int ST_OFLOW  = 3;

  function automatic logic [31:0] status_word(input logic nempty, input logic full,
                                              input logic uflow, input logic oflow);
    logic [31:0] w;
    w            = '0;
    w[ST_NEMPTY] = nempty;
    w[ST_FULL]   = full;
    w[ST_UFLOW]  = uflow;
    w[ST_OFLOW]  = oflow;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with head-of-queue output; caller guards push/pop
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/input_module.sv
// rtl/input_module.sv - memory-mapped input peripheral: producer FIFO drained by CPU loads
module input_module
  import io_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [4:0]       adress,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             data_avail
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] head;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             load_data;
  logic             store_status;
  logic             uflow;
  logic             oflow;
  logic             uflow_set;
  logic             oflow_set;

  // Ready follows the registered count, so a same-cycle pop never frees a slot.
  assign in_ready     = !full && !rst;
  assign push         = in_valid && in_ready;
  assign load_data    = MemRead && (adress == ADDR_DATA);
  assign pop          = load_data && !empty;
  assign store_status = MemWrite && !MemRead && (adress == ADDR_STATUS);
  assign uflow_set    = load_data && empty;
  assign oflow_set    = in_valid && !in_ready && !rst;
  assign data_avail   = !empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clock (clock),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Sets are applied after clears so a same-cycle set wins.
  always_ff @(posedge clock) begin
    if (rst) begin
      uflow <= 1'b0;
      oflow <= 1'b0;
    end else begin
      uflow <= (uflow && !(store_status && writedata[ST_UFLOW])) || uflow_set;
      oflow <= (oflow && !(store_status && writedata[ST_OFLOW])) || oflow_set;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      readdata <= '0;
    end else if (MemRead) begin
      case (adress)
        ADDR_DATA:   readdata <= empty ? 32'd0 : 32'(head);
        ADDR_STATUS: readdata <= status_word(!empty, full, uflow, oflow);
        ADDR_COUNT:  readdata <= 32'(count);
        default:     readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_input_module.sv
// tb/tb_input_module.sv - randomized and directed bench against a queue-based model
module tb_input_module;
  import io_pkg::*;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;

  logic             clock = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             MemRead;
  logic             MemWrite;
  logic [4:0]       adress;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic             data_avail;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q[$];
  logic        m_uf;
  logic        m_of;
  logic [31:0] m_rd;

  input_module #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock      (clock),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .adress     (adress),
    .writedata  (writedata),
    .readdata   (readdata),
    .data_avail (data_avail)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [31:0] d,
                       input logic mr, input logic mw, input logic [4:0] a,
                       input logic [31:0] wd);
    int   sz;
    logic exp_ready;
    logic uf_set;
    rst       = r;
    in_valid  = v;
    in_data   = d;
    MemRead   = mr;
    MemWrite  = mw;
    adress    = a;
    writedata = wd;
    #1;
    sz        = q.size();
    exp_ready = (sz != DEPTH) && !r;
    check("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
    @(posedge clock);
    uf_set = 1'b0;
    if (r) begin
      q.delete();
      m_uf = 1'b0;
      m_of = 1'b0;
      m_rd = 32'd0;
    end else begin
      if (mr) begin
        if (a == 5'd0) begin
          if (sz > 0) m_rd = q.pop_front();
          else begin
            m_rd   = 32'd0;
            uf_set = 1'b1;
          end
        end else if (a == 5'd1) begin
          m_rd = {28'b0, m_of, m_uf, (sz == DEPTH), (sz != 0)};
        end else if (a == 5'd2) begin
          m_rd = 32'(sz);
        end else begin
          m_rd = 32'd0;
        end
      end
      if (mw && !mr && a == 5'd1) begin
        if (wd[2]) m_uf = 1'b0;
        if (wd[3]) m_of = 1'b0;
      end
      if (uf_set) m_uf = 1'b1;
      if (v && !exp_ready) m_of = 1'b1;
      if (v && exp_ready) q.push_back(d);
    end
    #1;
    check("readdata", readdata, m_rd);
    check("data_avail", {31'b0, data_avail}, {31'b0, (q.size() != 0)});
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic push_word(input logic [31:0] d);
    cycle(1'b0, 1'b1, d, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic load(input logic [4:0] a);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic store_status(input logic [31:0] wd);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, ADDR_STATUS, wd);
  endtask

  initial begin
    m_uf = 1'b0;
    m_of = 1'b0;
    m_rd = 32'd0;

    cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 1'b1, 32'h1234, 1'b1, 1'b0, ADDR_DATA, 32'd0);
    load(ADDR_STATUS);
    check("status_after_reset", readdata, 32'h0);
    push_word(32'h55);
    load(ADDR_STATUS);
    check("status_one_word", readdata, 32'h1);
    load(ADDR_DATA);

    push_word(32'hA);
    push_word(32'hB);
    push_word(32'hC);
    load(ADDR_DATA);
    check("pop_a", readdata, 32'h0000000A);
    load(ADDR_DATA);
    check("pop_b", readdata, 32'h0000000B);
    load(ADDR_DATA);
    check("pop_c", readdata, 32'h0000000C);
    load(ADDR_DATA);
    check("pop_empty", readdata, 32'h0);
    load(ADDR_STATUS);
    check("status_uflow", readdata, 32'h4);

    store_status(32'hC);
    load(ADDR_STATUS);
    check("status_cleared", readdata, 32'h0);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, ADDR_DATA, 32'h4);
    load(ADDR_STATUS);

    cycle(1'b0, 1'b1, 32'h77, 1'b1, 1'b0, ADDR_DATA, 32'd0);
    load(ADDR_COUNT);
    load(ADDR_DATA);
    store_status(32'hC);

    for (int i = 0; i < DEPTH + 1; i++) push_word(32'h100 + 32'(i));
    cycle(1'b0, 1'b1, 32'h108, 1'b1, 1'b0, ADDR_STATUS, 32'd0);
    check("status_full_oflow", readdata, 32'hB);
    cycle(1'b0, 1'b1, 32'h108, 1'b1, 1'b0, ADDR_COUNT, 32'd0);
    check("count_full", readdata, 32'd8);
    cycle(1'b0, 1'b1, 32'h108, 1'b1, 1'b0, ADDR_DATA, 32'd0);
    cycle(1'b0, 1'b1, 32'h108, 1'b0, 1'b0, 5'd0, 32'd0);
    load(ADDR_COUNT);
    store_status(32'hC);
    for (int i = 0; i < DEPTH; i++) load(ADDR_DATA);
    load(ADDR_STATUS);
    store_status(32'hC);

    for (int i = 0; i < 3; i++) push_word(32'h200 + 32'(i));
    for (int i = 0; i < 20; i++)
      cycle(1'b0, 1'b1, 32'h300 + 32'(i), 1'b1, 1'b0, ADDR_DATA, 32'd0);
    load(ADDR_COUNT);
    check("count_steady", readdata, 32'd3);

    for (int i = 0; i < 2; i++) push_word(32'h400 + 32'(i));
    cycle(1'b1, 1'b1, 32'h999, 1'b1, 1'b0, ADDR_DATA, 32'd0);
    check("readdata_after_rst", readdata, 32'h0);
    load(ADDR_COUNT);
    check("count_after_rst", readdata, 32'h0);
    idle();

    for (int i = 0; i < 800; i++) begin
      logic [4:0] a;
      a = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
      cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 99) < 55), $urandom,
            ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 20), a, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
